// File: rtl/ripemd160_padder.sv
// ripemd160_padder: packs a 32-bit word message stream into padded 512-bit RIPEMD-160 blocks.
// Latency: a full data block is valid 1 cycle after its 16th word; the final block is valid 2 cycles after i_last.
// Backpressure: i_ready is low outside FILL, and a block is held stable until o_valid && o_ready.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   i_valid/i_ready       word handshake; i_data lanes little-endian, i_bytes valid bytes of the i_last word
//   o_valid/o_ready       block handshake; o_block X[0] at [511:480], o_last marks the digest-final block
// Optional build macro: RIPEMD_PAD_BSWAP_EN (treat i_data as big-endian and byte-swap before storing)
module ripemd160_padder #(
  parameter int LEN_BITS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [31:0]  i_data,
  input  logic [2:0]   i_bytes,
  input  logic         i_last,
  output logic         i_ready,
  output logic         o_valid,
  output logic [511:0] o_block,
  output logic         o_last,
  input  logic         o_ready
);

  // Byte counter width; the bit length is this count shifted left by 3.
  localparam int LW = LEN_BITS - 3;

  typedef enum logic [1:0] {FILL, PAD, EMIT, EXTRA} state_t;

  state_t        state_q;
  logic [31:0]   x_q [16];
  logic [3:0]    widx_q;
  logic [6:0]    pcnt_q;    // message bytes in the current block, 0..64
  logic [LW-1:0] len_q;
  logic          pend_q;    // length-only block still owed
  logic          mark_q;    // that block also carries the 0x80 marker
  logic          valid_q;
  logic          last_q;

  logic [31:0]   din;
  logic [2:0]    nb;
  logic [31:0]   mask;
  logic [LW-1:0] len_d;
  logic [6:0]    pcnt_d;
  logic [63:0]   bitlen;

  always_comb begin
`ifdef RIPEMD_PAD_BSWAP_EN
    din = {i_data[7:0], i_data[15:8], i_data[23:16], i_data[31:24]};
`else
    din = i_data;
`endif
    // Non-last words always count 4 bytes; a last-word count above 4 is clamped.
    nb = i_last ? ((i_bytes > 3'd4) ? 3'd4 : i_bytes) : 3'd4;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      mask[8*k +: 8] = (3'(k) < nb) ? 8'hFF : 8'h00;
    end
    len_d  = len_q + LW'(nb);
    pcnt_d = pcnt_q + 7'(nb);
    bitlen = 64'({len_q, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      for (int j = 0; j < 16; j++) x_q[j] <= '0;
      widx_q  <= '0;
      pcnt_q  <= '0;
      len_q   <= '0;
      pend_q  <= 1'b0;
      mark_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (i_valid) begin
            x_q[widx_q] <= din & mask;
            len_q       <= len_d;
            pcnt_q      <= pcnt_d;
            widx_q      <= widx_q + 4'd1;
            if (i_last) begin
              state_q <= PAD;
            end else if (widx_q == 4'd15) begin
              state_q <= EMIT;
              valid_q <= 1'b1;
              last_q  <= 1'b0;
            end
          end
        end
        PAD: begin
          state_q <= EMIT;
          valid_q <= 1'b1;
          // Bytes after the marker are already zero: X is cleared per block and
          // invalid lanes are masked on write.
          if (pcnt_q < 7'd64) begin
            x_q[pcnt_q[5:2]][{pcnt_q[1:0], 3'b000} +: 8] <= 8'h80;
          end
          if (pcnt_q < 7'd56) begin
            x_q[14] <= bitlen[31:0];
            x_q[15] <= bitlen[63:32];
            last_q  <= 1'b1;
          end else begin
            // No room for the length field: a second block follows.
            last_q <= 1'b0;
            pend_q <= 1'b1;
            mark_q <= (pcnt_q == 7'd64);
          end
        end
        EXTRA: begin
          x_q[0]  <= mark_q ? 32'h0000_0080 : 32'h0;
          x_q[14] <= bitlen[31:0];
          x_q[15] <= bitlen[63:32];
          mark_q  <= 1'b0;
          last_q  <= 1'b1;
          valid_q <= 1'b1;
          state_q <= EMIT;
        end
        EMIT: begin
          if (o_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int j = 0; j < 16; j++) x_q[j] <= '0;
            if (pend_q) begin
              pend_q  <= 1'b0;
              state_q <= EXTRA;
            end else begin
              state_q <= FILL;
              widx_q  <= '0;
              pcnt_q  <= '0;
              if (last_q) len_q <= '0;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign i_ready = (state_q == FILL) && !rst;
  assign o_valid = valid_q;
  assign o_last  = last_q;

  always_comb begin
    o_block = '0;
    for (int j = 0; j < 16; j++) begin
      o_block[511-32*j -: 32] = x_q[j];
    end
  end

endmodule

// File: tb/tb_ripemd160_padder.sv
// tb_ripemd160_padder: directed scenarios against hand-derived padded blocks.
module tb_ripemd160_padder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic [31:0]  i_data = '0;
  logic [2:0]   i_bytes = '0;
  logic         i_last = 1'b0;
  logic         i_ready;
  logic         o_valid;
  logic [511:0] o_block;
  logic         o_last;
  logic         o_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0]  ex [16];
  logic [511:0] saved;

`ifdef RIPEMD_PAD_BSWAP_EN
  localparam logic [31:0] ABC_W = 32'h6162_6300;
`else
  localparam logic [31:0] ABC_W = 32'h0063_6261;
`endif

  always #5 clk = ~clk;

  ripemd160_padder dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_bytes(i_bytes),
    .i_last(i_last), .i_ready(i_ready), .o_valid(o_valid), .o_block(o_block),
    .o_last(o_last), .o_ready(o_ready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Message byte n has value n; word k carries bytes 4k..4k+3.
  function automatic logic [31:0] wd(input int k);
    return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
  endfunction

  // How a driven word lands in X.
  function automatic logic [31:0] st(input logic [31:0] w);
`ifdef RIPEMD_PAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [511:0] pack_ex();
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[511-32*j -: 32] = ex[j];
    return r;
  endfunction

  task automatic clear_ex();
    for (int j = 0; j < 16; j++) ex[j] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic [2:0] b, input logic l);
    i_valid = 1'b1; i_data = d; i_bytes = b; i_last = l;
    step();
    i_valid = 1'b0; i_data = '0; i_bytes = '0; i_last = 1'b0;
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 40 && o_valid !== 1'b1; c++) step();
  endtask

  task automatic handshake();
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready got %b exp 0", i_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_o_valid got %b exp 0", o_valid); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL rst_o_last got %b exp 0", o_last); end
    checks++; if (o_block !== 512'h0) begin errors++; $display("FAIL rst_o_block got %h exp 0", o_block); end
    rst = 1'b0;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL rst_release_i_ready got %b exp 1", i_ready); end
    step();
  endtask

  task automatic test_abc();
    clear_ex();
    ex[0] = 32'h8063_6261; ex[14] = 32'h0000_0018;
    put(ABC_W, 3'd4 - 3'd1, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL abc_pad_valid got %b exp 0", o_valid); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL abc_pad_ready got %b exp 0", i_ready); end
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL abc_valid got %b exp 1", o_valid); end
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL abc_block got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL abc_last got %b exp 1", o_last); end
    handshake();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL abc_valid_fall got %b exp 0", o_valid); end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL abc_ready_back got %b exp 1", i_ready); end
  endtask

  task automatic test_empty();
    clear_ex();
    ex[0] = 32'h0000_0080;
    o_ready = 1'b1;   // held with no block pending
    step(); step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL empty_idle_valid got %b exp 0", o_valid); end
    put(32'hFFFF_FFFF, 3'd0, 1'b1);
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL empty_valid got %b exp 1", o_valid); end
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL empty_block got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL empty_last got %b exp 1", o_last); end
    step();
    o_ready = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL empty_consumed got %b exp 0", o_valid); end
  endtask

  task automatic test_56();
    for (int k = 0; k < 14; k++) put(wd(k), 3'd4, k == 13);
    clear_ex();
    for (int k = 0; k < 14; k++) ex[k] = st(wd(k));
    ex[14] = 32'h0000_0080;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b56_pad_valid got %b exp 0", o_valid); end
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b56_valid1 got %b exp 1", o_valid); end
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL b56_block1 got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL b56_last1 got %b exp 0", o_last); end
    handshake();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b56_extra_valid got %b exp 0", o_valid); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL b56_extra_ready got %b exp 0", i_ready); end
    step();
    clear_ex();
    ex[14] = 32'h0000_01C0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b56_valid2 got %b exp 1", o_valid); end
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL b56_block2 got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL b56_last2 got %b exp 1", o_last); end
    handshake();
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL b56_ready_back got %b exp 1", i_ready); end
  endtask

  // 61 bytes: marker lands in lane 1 of X[15].
  task automatic test_61();
    for (int k = 0; k < 16; k++) put(wd(k), (k == 15) ? 3'd1 : 3'd4, k == 15);
    clear_ex();
    for (int k = 0; k < 15; k++) ex[k] = st(wd(k));
    ex[15] = (st(wd(15)) & 32'h0000_00FF) | 32'h0000_8000;
    wait_valid();
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL b61_block1 got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL b61_last1 got %b exp 0", o_last); end
    handshake();
    wait_valid();
    clear_ex();
    ex[14] = 32'h0000_01E8;
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL b61_block2 got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL b61_last2 got %b exp 1", o_last); end
    handshake();
  endtask

  task automatic test_64();
    for (int k = 0; k < 16; k++) put(wd(k), 3'd4, k == 15);
    clear_ex();
    for (int k = 0; k < 16; k++) ex[k] = st(wd(k));
    wait_valid();
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL b64_block1 got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL b64_last1 got %b exp 0", o_last); end
    handshake();
    wait_valid();
    clear_ex();
    ex[0] = 32'h0000_0080; ex[14] = 32'h0000_0200;
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL b64_block2 got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL b64_last2 got %b exp 1", o_last); end
    handshake();
  endtask

  // 68 bytes: a full data block, then a final block whose length spans both.
  task automatic test_multi();
    for (int k = 0; k < 16; k++) put(wd(k), 3'd4, 1'b0);
    clear_ex();
    for (int k = 0; k < 16; k++) ex[k] = st(wd(k));
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b68_full_valid got %b exp 1", o_valid); end
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL b68_block1 got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL b68_last1 got %b exp 0", o_last); end
    handshake();
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL b68_ready_back got %b exp 1", i_ready); end
    put(wd(16), 3'd4, 1'b1);
    step();
    clear_ex();
    ex[0] = st(wd(16)); ex[1] = 32'h0000_0080; ex[14] = 32'h0000_0220;
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL b68_block2 got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL b68_last2 got %b exp 1", o_last); end
    handshake();
  endtask

  task automatic test_backpressure();
    put(ABC_W, 3'd3, 1'b1);
    step();
    saved = o_block;
    clear_ex();
    ex[0] = 32'h8063_6261; ex[14] = 32'h0000_0018;
    checks++; if (saved !== pack_ex()) begin errors++; $display("FAIL bp_block got %h exp %h", saved, pack_ex()); end
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1; i_data = 32'hDEAD_BEEF; i_bytes = 3'd4; i_last = 1'b1;
      step();
      checks++; if (o_block !== saved) begin errors++; $display("FAIL bp_hold_block cycle %0d got %h exp %h", c, o_block, saved); end
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b exp 1", c, o_valid); end
      checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready cycle %0d got %b exp 0", c, i_ready); end
    end
    i_valid = 1'b0; i_last = 1'b0; i_data = '0; i_bytes = '0;
    handshake();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_fall got %b exp 0", o_valid); end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", i_ready); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 7; k++) put(wd(k), 3'd4, 1'b0);
    rst = 1'b1;
    step();
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL rmid_i_ready got %b exp 0", i_ready); end
    rst = 1'b0;
    put(ABC_W, 3'd3, 1'b1);
    step();
    clear_ex();
    ex[0] = 32'h8063_6261; ex[14] = 32'h0000_0018;
    checks++; if (o_block !== pack_ex()) begin errors++; $display("FAIL rmid_block got %h exp %h", o_block, pack_ex()); end
    checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL rmid_last got %b exp 1", o_last); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_56();
    test_61();
    test_64();
    test_multi();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripemd160_padder.md
# ripemd160_padder

- Upstream message formatter for the RIPEMD-160 core.
- Accepts an arbitrary-length byte message as 32-bit words and emits padded 512-bit blocks: data, 0x80 marker, zero fill, 64-bit little-endian bit length.
- Blocks use the same 512-bit `block` / valid convention the core consumes.
- Sits between the SHA-256 stage (Hash160 chain) or a host byte stream and the RIPEMD-160 core; `o_last` marks the block whose digest is final.

## Interface
- `LEN_BITS`, default 64: width of the internal bit-length counter (8..64). Length-field bits at or above `LEN_BITS` are zero.
- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_valid` input 1: input word valid.
- `i_data` input 32: message bytes, little-endian lanes; first byte in [7:0].
- `i_bytes` input 3: valid byte count (0..4) of the `i_last` word. Must be 4 on non-last words. Valid bytes occupy the low lanes.
- `i_last` input 1: word is the final word of the message.
- `i_ready` output 1: word accepted on an edge where `i_valid && i_ready`.
- `o_valid` output 1: `o_block` holds a complete block.
- `o_block` output 512: message word X[j] at bits [511-32j -: 32], so X[0] is at [511:480].
- `o_last` output 1: block is the final block of the message.
- `o_ready` input 1: block consumed on an edge where `o_valid && o_ready`.

## Operation
- States:
  - FILL (reset state): accept words into X[0..15], word index `widx`.
  - PAD: apply padding after `i_last`.
  - EMIT: hold block until handshake.
  - EXTRA: build the length-only second block.
- FILL:
  - Each accepted word is written to X[widx] with invalid lanes zeroed.
  - Byte counter `len` += `i_bytes`, or += 4 for non-last words.
  - 16th word without `i_last` → EMIT, `o_last`=0.
  - `i_last` → PAD.
- PAD (one cycle). Let p = message bytes in the current block (0..64).
  - p<56: byte p = 0x80, bytes p+1..55 = 0. X[14] = bit length [31:0], X[15] = bit length [63:32], where bit length = `len`*8. → EMIT with `o_last`=1.
  - 56≤p<64: byte p = 0x80, remainder zero. → EMIT with `o_last`=0, then EXTRA.
  - p=64 (block filled exactly by `i_last`): emit the data block with `o_last`=0, then EXTRA with X[0]=0x00000080.
- EXTRA (one cycle): X[0..13] zero except the marker case above; X[14]/X[15] = length. → EMIT with `o_last`=1.
- EMIT:
  - On handshake, return to FILL (clear X, `widx`=0) or go to EXTRA if pending.
  - After an `o_last` handshake, also clear `len`.
- Arithmetic: `len` wraps modulo 2^(LEN_BITS-3).
- Boundary behaviour:
  - `i_valid` outside FILL is ignored (`i_ready`=0).
  - `o_ready` without `o_valid` is ignored.
  - `i_bytes`=0 with `i_last` is legal; the empty message gives X[0]=0x00000080 and X[14]=0.
  - `rst` mid-message discards the partial block, `len` and any pending EXTRA. The next accepted word starts a new message.

## Timing
- Reset values: `o_valid`=0, `o_last`=0, `o_block`=0, `i_ready`=0 while `rst` high. `i_ready`=1 the first cycle after `rst` falls.
- Throughput: one word per cycle in FILL.
- Full data block: `o_valid` rises the cycle after the 16th accepting edge.
- Final block: `o_valid` rises two cycles after the `i_last` accepting edge (PAD cycle).
- Second block: `o_valid` rises two cycles after the first block's handshake (EXTRA cycle).
- While `o_valid`=1: `o_block` and `o_last` are stable until the handshake edge; `o_valid` falls the cycle after it.
- `i_ready`=0 in PAD, EMIT and EXTRA.

## Configuration
- `RIPEMD_PAD_BSWAP_EN`
- Defined: `i_data` is treated as big-endian (SHA-256 digest word order). Bytes are swapped ([31:24]↔[7:0], [23:16]↔[15:8]) before storage; for `i_bytes`<4 the valid bytes are in the high lanes.
- Undefined: `i_data` is stored as-is, little-endian.
- Length counting and padding are identical in both builds.

## Test plan
- "abc": `i_data`=0x00636261, `i_bytes`=3, `i_last` → one block, X[0]=0x80636261, X[14]=0x00000018, others 0, `o_last`=1, `o_valid` two cycles after accept.
- Empty message: `i_bytes`=0, `i_last` → X[0]=0x00000080, all else 0, `o_last`=1.
- 56-byte message (14 words, last `i_bytes`=4):
  - Block 1: X[14]=0x00000080, X[15]=0, `o_last`=0.
  - Block 2: all zero except X[14]=0x000001C0, `o_last`=1.
- 64-byte message → data block with `o_last`=0, then X[0]=0x00000080, X[14]=0x00000200, `o_last`=1.
- Backpressure: `o_ready`=0 for 5 cycles with `o_valid`=1 → `o_block` constant, `i_ready`=0, `i_valid` words ignored; `o_ready`=1 → `o_valid` falls next cycle, `i_ready`=1.
- Reset mid-message after 7 words, then "abc" → output identical to the "abc" case. With `RIPEMD_PAD_BSWAP_EN`, `i_data`=0x61626300 gives the same block.
